// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: in-order imem request/grant/response handshake, prefetch FIFO, IF/ID register.
// Optional: define IF_PERF_CNT_EN to add perf_fetch_cnt / perf_bubble_cnt outputs.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        id_stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        if_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_bubble_cnt
`endif
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [31:0]   fpc;
  logic [31:0]   rpc;
  logic [1:0]    outstanding;
  logic [1:0]    drop;
  logic [31:0]   pc_mem  [FIFO_DEPTH];
  logic [31:0]   ins_mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic        redirect;
  logic        grant;
  logic        rsp;
  logic        push;
  logic        pop;
  logic [31:0] level;
  logic [31:0] target;

  // A response with nothing outstanding is a leftover from before reset and is ignored.
  always_comb begin
    redirect  = branch_taken && !id_stall;
    target    = branch_target & ~32'd3;
    level     = 32'(count) + 32'(outstanding);
    imem_req  = rst && (level < FIFO_DEPTH) && (outstanding < 2'd2) && !redirect;
    imem_addr = fpc;
    grant     = imem_req && imem_gnt;
    rsp       = imem_rvalid && (outstanding != 2'd0);
    push      = rsp && (drop == 2'd0) && !redirect;
    pop       = !id_stall && !branch_taken && (count != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fpc         <= RESET_PC;
      rpc         <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      case ({grant, rsp})
        2'b10:   outstanding <= outstanding + 2'd1;
        2'b01:   outstanding <= outstanding - 2'd1;
        default: outstanding <= outstanding;
      endcase

      // Everything still in flight at a redirect belongs to the old stream.
      if (redirect) begin
        drop <= outstanding - {1'b0, rsp};
      end else if (rsp && (drop != 2'd0)) begin
        drop <= drop - 2'd1;
      end

      if (redirect) begin
        fpc <= target;
      end else if (grant) begin
        fpc <= fpc + 32'd4;
      end

      if (redirect) begin
        rpc <= target;
      end else if (push) begin
        rpc <= rpc + 32'd4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]  <= rpc;
      ins_mem[wr_ptr] <= imem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instruction <= NOP;
      pc          <= RESET_PC;
      if_valid    <= 1'b0;
    end else if (!id_stall) begin
      if (pop) begin
        instruction <= ins_mem[rd_ptr];
        pc          <= pc_mem[rd_ptr];
        if_valid    <= 1'b1;
      end else begin
        instruction <= NOP;
        if_valid    <= 1'b0;
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else if (!id_stall) begin
      if (pop) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end else begin
        perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
